writeback_arbiter: RTL and testbench

//  Writeback stage directly upstream of the register file. Merges single-cycle pipeline

---
 rtl/writeback_arbiter_pkg.sv | 28 ++
 rtl/wb_result_fifo.sv | 110 +++++++++++
 rtl/writeback_arbiter.sv | 102 ++++++++++
 tb/tb_writeback_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// rtl/writeback_arbiter_pkg.sv - shared constants and types for the writeback arbiter
//
// Purpose: register-index constants, mult/div exception codes, and the buffered
// writeback entry type shared by writeback_arbiter and wb_result_fifo.
// Ports: none (package).

package writeback_arbiter_pkg;

  localparam int REG_ZERO = 0;
  localparam int RSTATUS  = 30;
  localparam int EXC_MULT = 4;
  localparam int EXC_DIV  = 5;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  // One-hot decode of a register index; register 0 is never reported pending.
  function automatic logic [31:0] rd_decode(input logic [4:0] rd);
    logic [31:0] onehot;
    onehot    = 32'd1 << rd;
    onehot[0] = 1'b0;
    return onehot;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// rtl/wb_result_fifo.sv - circular buffer of mult/div results with kill-by-rd
//
// Purpose: DEPTH-entry circular FIFO of writeback entries. Each slot carries a valid
// bit so a younger pipeline write can kill older buffered results in place; killed
// slots stay as holes and are skipped one per cycle when they reach the head.
// Ports:
//   clock, reset          in   clock, synchronous active-high reset
//   push, push_rd/data    in   enqueue request (ignored when not ready)
//   pop                   in   consume the head entry (only honoured when head_valid)
//   kill, kill_rd         in   invalidate every buffered entry whose rd matches
//   ready                 out  count < DEPTH (combinational from current count)
//   head_valid/rd/data    out  head slot contents, valid only if occupied and not killed
//   pending_mask          out  registered OR of rd-decodes of valid entries

module wb_result_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic [4:0]  push_rd,
  input  logic [31:0] push_data,
  input  logic        pop,
  input  logic        kill,
  input  logic [4:0]  kill_rd,
  output logic        ready,
  output logic        head_valid,
  output logic [4:0]  head_rd,
  output logic [31:0] head_data,
  output logic [31:0] pending_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       entries     [DEPTH];
  wb_entry_t       entries_nxt [DEPTH];
  logic [PW-1:0]   rd_ptr, rd_ptr_nxt;
  logic [PW-1:0]   wr_ptr, wr_ptr_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic [31:0]     mask_nxt;
  logic            push_ok;
  logic            advance;

  assign ready      = (count < CW'(DEPTH));
  assign head_valid = (count != '0) && entries[rd_ptr].valid;
  assign head_rd    = entries[rd_ptr].rd;
  assign head_data  = entries[rd_ptr].data;
  assign push_ok    = push && ready;

  always_comb begin
    entries_nxt = entries;
    rd_ptr_nxt  = rd_ptr;
    wr_ptr_nxt  = wr_ptr;
    mask_nxt    = '0;

    if (kill) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entries[i].valid && (entries[i].rd == kill_rd)) begin
          entries_nxt[i].valid = 1'b0;
        end
      end
    end

    // The head moves on either when it is consumed or when it is a hole left by a
    // kill; validity is judged on the current state, so a head killed this cycle is
    // skipped next cycle.
    advance = (count != '0) && ((pop && entries[rd_ptr].valid) || !entries[rd_ptr].valid);
    if (advance) begin
      entries_nxt[rd_ptr].valid = 1'b0;
      rd_ptr_nxt                = rd_ptr + PW'(1);
    end

    // The write slot is never an occupied slot when ready, so writing after the
    // kill loop lets a same-cycle push to the killed rd survive as the younger result.
    if (push_ok) begin
      entries_nxt[wr_ptr] = '{valid: 1'b1, rd: push_rd, data: push_data};
      wr_ptr_nxt          = wr_ptr + PW'(1);
    end

    count_nxt = count + CW'(push_ok) - CW'(advance);

    for (int i = 0; i < DEPTH; i++) begin
      if (entries_nxt[i].valid) begin
        mask_nxt = mask_nxt | rd_decode(entries_nxt[i].rd);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      pending_mask <= '0;
    end else begin
      entries      <= entries_nxt;
      rd_ptr       <= rd_ptr_nxt;
      wr_ptr       <= wr_ptr_nxt;
      count        <= count_nxt;
      pending_mask <= mask_nxt;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges pipeline and mult/div results onto the regfile port
//
// Purpose: single regfile write port shared by the MEM/WB pipeline result (absolute
// priority, never stalls) and out-of-order mult/div completions, which are buffered
// when they lose arbitration. Exports a pending-register mask for decode stalls.
// Ports:
//   clock, ctrl_reset                  in   clock, synchronous active-high reset
//   pipe_valid, pipe_rd, pipe_data     in   MEM/WB result
//   md_valid, md_rd, md_data           in   mult/div completion offer
//   md_exception, md_is_div            in   exception flag and unit select
//   md_ready                           out  buffer can accept (combinational)
//   pending_mask                       out  registered mask of buffered destinations
//   ctrl_writeEnable/WriteReg, data_writeReg  out  registered regfile write

module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int RSTATUS  = writeback_arbiter_pkg::RSTATUS,
  parameter int EXC_MULT = writeback_arbiter_pkg::EXC_MULT,
  parameter int EXC_DIV  = writeback_arbiter_pkg::EXC_DIV
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  input  logic        md_exception,
  input  logic        md_is_div,
  output logic        md_ready,
  output logic [31:0] pending_mask,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);

  logic [4:0]  md_rd_eff;
  logic [31:0] md_data_eff;
  logic        pipe_win;
  logic        md_push;
  logic        head_pop;
  logic        head_valid;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  // An exception replaces the completion with a status-register write carrying the
  // unit's exception code; the original destination and data are discarded.
  always_comb begin
    md_rd_eff   = md_rd;
    md_data_eff = md_data;
    if (md_exception) begin
      md_rd_eff   = 5'(RSTATUS);
      md_data_eff = md_is_div ? 32'(EXC_DIV) : 32'(EXC_MULT);
    end
  end

  assign pipe_win = pipe_valid && (pipe_rd != 5'(REG_ZERO));
  // Writes to r0 are handshaken so the unit is not blocked, but never buffered.
  assign md_push  = md_valid && md_ready && (md_rd_eff != 5'(REG_ZERO));
  assign head_pop = !pipe_win && head_valid;

  wb_result_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock        (clock),
    .reset        (ctrl_reset),
    .push         (md_push),
    .push_rd      (md_rd_eff),
    .push_data    (md_data_eff),
    .pop          (head_pop),
    .kill         (pipe_win),
    .kill_rd      (pipe_rd),
    .ready        (md_ready),
    .head_valid   (head_valid),
    .head_rd      (head_rd),
    .head_data    (head_data),
    .pending_mask (pending_mask)
  );

  // Address and data hold their last values on idle cycles; only the enable drops.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else if (pipe_win) begin
      ctrl_writeEnable <= 1'b1;
      ctrl_writeReg    <= pipe_rd;
      data_writeReg    <= pipe_data;
    end else if (head_valid) begin
      ctrl_writeEnable <= 1'b1;
      ctrl_writeReg    <= head_rd;
      data_writeReg    <= head_data;
    end else begin
      ctrl_writeEnable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - self-checking bench for writeback_arbiter

module tb_writeback_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_exception;
  logic        md_is_div;
  logic        md_ready;
  logic [31:0] pending_mask;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  always #5 clock = ~clock;

  writeback_arbiter #(.DEPTH(2)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .pipe_valid       (pipe_valid),
    .pipe_rd          (pipe_rd),
    .pipe_data        (pipe_data),
    .md_valid         (md_valid),
    .md_rd            (md_rd),
    .md_data          (md_data),
    .md_exception     (md_exception),
    .md_is_div        (md_is_div),
    .md_ready         (md_ready),
    .pending_mask     (pending_mask),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic mexc, input logic mdiv);
    pipe_valid   = pv;
    pipe_rd      = prd;
    pipe_data    = pd;
    md_valid     = mv;
    md_rd        = mrd;
    md_data      = md;
    md_exception = mexc;
    md_is_div    = mdiv;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  typedef struct {
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        mexc;
    logic        mdiv;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [31:0] mask;
    logic        rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                              input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                              input logic mexc, input logic mdiv,
                              input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                              input logic [31:0] mask, input logic rdy);
    vec_t v;
    v.pv = pv; v.prd = prd; v.pd = pd;
    v.mv = mv; v.mrd = mrd; v.md = md; v.mexc = mexc; v.mdiv = mdiv;
    v.we = we; v.wreg = wreg; v.wdata = wdata; v.mask = mask; v.rdy = rdy;
    return v;
  endfunction

  typedef struct {
    bit        v;
    bit [4:0]  rd;
    bit [31:0] d;
  } m_ent_t;

  typedef struct {
    bit        we;
    bit [4:0]  r;
    bit [31:0] d;
  } exp_t;

  m_ent_t mq[$];
  exp_t   sb[$];

  initial begin
    ctrl_reset = 1'b1;
    idle();
    tick();
    tick();
    ctrl_reset = 1'b0;
    check("reset_we",    32'(ctrl_writeEnable), 32'd0);
    check("reset_reg",   32'(ctrl_writeReg),    32'd0);
    check("reset_data",  data_writeReg,         32'd0);
    check("reset_mask",  pending_mask,          32'd0);
    check("reset_ready", 32'(md_ready),         32'd1);

    //        pv prd  pd            mv mrd  md           exc div  we reg  data          mask          rdy
    vecs.push_back(mk(1, 5,  32'h1234,    0, 0,  32'h0,      0, 0,  1, 5,  32'h1234,    32'h0,        1));
    vecs.push_back(mk(1, 0,  32'hdead,    0, 0,  32'h0,      0, 0,  0, 5,  32'h1234,    32'h0,        1));
    vecs.push_back(mk(1, 3,  32'h33,      1, 7,  32'h99,     0, 0,  1, 3,  32'h33,      32'h80,       1));
    vecs.push_back(mk(0, 0,  32'h0,       0, 0,  32'h0,      0, 0,  1, 7,  32'h99,      32'h0,        1));
    vecs.push_back(mk(0, 0,  32'h0,       0, 0,  32'h0,      0, 0,  0, 7,  32'h99,      32'h0,        1));
    vecs.push_back(mk(1, 1,  32'h101,     1, 10, 32'ha0,     0, 0,  1, 1,  32'h101,     32'h400,      1));
    vecs.push_back(mk(1, 2,  32'h202,     1, 11, 32'hb0,     0, 0,  1, 2,  32'h202,     32'hc00,      0));
    vecs.push_back(mk(1, 4,  32'h404,     1, 12, 32'hc0,     0, 0,  1, 4,  32'h404,     32'hc00,      0));
    vecs.push_back(mk(0, 0,  32'h0,       1, 12, 32'hc0,     0, 0,  1, 10, 32'ha0,      32'h800,      1));
    vecs.push_back(mk(0, 0,  32'h0,       1, 12, 32'hc0,     0, 0,  1, 11, 32'hb0,      32'h1000,     1));
    vecs.push_back(mk(0, 0,  32'h0,       0, 0,  32'h0,      0, 0,  1, 12, 32'hc0,      32'h0,        1));
    vecs.push_back(mk(1, 6,  32'h66,      1, 9,  32'h999,    0, 0,  1, 6,  32'h66,      32'h200,      1));
    vecs.push_back(mk(1, 9,  32'h5555,    0, 0,  32'h0,      0, 0,  1, 9,  32'h5555,    32'h0,        1));
    vecs.push_back(mk(0, 0,  32'h0,       0, 0,  32'h0,      0, 0,  0, 9,  32'h5555,    32'h0,        1));
    vecs.push_back(mk(0, 0,  32'h0,       0, 0,  32'h0,      0, 0,  0, 9,  32'h5555,    32'h0,        1));
    vecs.push_back(mk(0, 0,  32'h0,       1, 17, 32'hffff,   1, 1,  0, 9,  32'h5555,    32'h40000000, 1));
    vecs.push_back(mk(0, 0,  32'h0,       1, 0,  32'h1234,   1, 0,  1, 30, 32'h5,       32'h40000000, 1));
    vecs.push_back(mk(0, 0,  32'h0,       0, 0,  32'h0,      0, 0,  1, 30, 32'h4,       32'h0,        1));
    vecs.push_back(mk(0, 0,  32'h0,       1, 0,  32'h77,     0, 0,  0, 30, 32'h4,       32'h0,        1));
    vecs.push_back(mk(0, 0,  32'h0,       0, 0,  32'h0,      0, 0,  0, 30, 32'h4,       32'h0,        1));
    vecs.push_back(mk(1, 8,  32'h81,      1, 8,  32'h82,     0, 0,  1, 8,  32'h81,      32'h100,      1));
    vecs.push_back(mk(0, 0,  32'h0,       0, 0,  32'h0,      0, 0,  1, 8,  32'h82,      32'h0,        1));
    vecs.push_back(mk(0, 0,  32'h0,       0, 0,  32'h0,      0, 0,  0, 8,  32'h82,      32'h0,        1));
    vecs.push_back(mk(1, 1,  32'h11,      1, 20, 32'h2020,   0, 0,  1, 1,  32'h11,      32'h100000,   1));
    vecs.push_back(mk(1, 2,  32'h22,      1, 21, 32'h2121,   0, 0,  1, 2,  32'h22,      32'h300000,   0));
    vecs.push_back(mk(1, 21, 32'h77,      0, 0,  32'h0,      0, 0,  1, 21, 32'h77,      32'h100000,   0));
    vecs.push_back(mk(0, 0,  32'h0,       0, 0,  32'h0,      0, 0,  1, 20, 32'h2020,    32'h0,        1));
    vecs.push_back(mk(0, 0,  32'h0,       0, 0,  32'h0,      0, 0,  0, 20, 32'h2020,    32'h0,        1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pv, vecs[i].prd, vecs[i].pd, vecs[i].mv, vecs[i].mrd, vecs[i].md,
            vecs[i].mexc, vecs[i].mdiv);
      tick();
      check($sformatf("v%0d_we", i),    32'(ctrl_writeEnable), 32'(vecs[i].we));
      check($sformatf("v%0d_reg", i),   32'(ctrl_writeReg),    32'(vecs[i].wreg));
      check($sformatf("v%0d_data", i),  data_writeReg,         vecs[i].wdata);
      check($sformatf("v%0d_mask", i),  pending_mask,          vecs[i].mask);
      check($sformatf("v%0d_ready", i), 32'(md_ready),         32'(vecs[i].rdy));
    end

    // Reset in the middle of traffic with a full buffer.
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd13, 32'hd13, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd14, 32'hd14, 1'b0, 1'b0);
    tick();
    check("midrst_pre_mask", pending_mask, 32'h6000);
    drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd15, 32'hd15, 1'b0, 1'b0);
    ctrl_reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("midrst%0d_we", k),    32'(ctrl_writeEnable), 32'd0);
      check($sformatf("midrst%0d_mask", k),  pending_mask,          32'd0);
      check($sformatf("midrst%0d_ready", k), 32'(md_ready),         32'd1);
    end
    ctrl_reset = 1'b0;
    idle();
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("postrst%0d_we", k),   32'(ctrl_writeEnable), 32'd0);
      check($sformatf("postrst%0d_mask", k), pending_mask,          32'd0);
    end

    // Randomized traffic against a reference model, results through a scoreboard.
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    mq.delete();
    sb.delete();
    for (int c = 0; c < 400; c++) begin
      logic        pv, mv, mexc, mdiv, win, hpop, hskip, rdy;
      logic [4:0]  prd, mrd, erd;
      logic [31:0] pd, md, ed, emask;
      int          r;
      exp_t        e;
      m_ent_t      ne;

      pv   = ($urandom_range(0, 99) < 50);
      r    = $urandom_range(0, 9);
      prd  = (r > 7) ? 5'd30 : 5'(r);
      pd   = $urandom;
      mv   = ($urandom_range(0, 99) < 60);
      r    = $urandom_range(0, 9);
      mrd  = (r > 7) ? 5'd30 : 5'(r);
      md   = $urandom;
      mexc = ($urandom_range(0, 99) < 10);
      mdiv = 1'($urandom_range(0, 1));
      drive(pv, prd, pd, mv, mrd, md, mexc, mdiv);

      rdy   = (mq.size() < 2);
      win   = pv && (prd != 5'd0);
      hpop  = !win && (mq.size() > 0) && mq[0].v;
      hskip = (mq.size() > 0) && !mq[0].v;
      e.we = 1'b0; e.r = '0; e.d = '0;
      if (win) begin
        e.we = 1'b1; e.r = prd; e.d = pd;
      end else if (hpop) begin
        e.we = 1'b1; e.r = mq[0].rd; e.d = mq[0].d;
      end
      sb.push_back(e);
      if (win) begin
        foreach (mq[j]) if (mq[j].v && mq[j].rd == prd) mq[j].v = 1'b0;
      end
      if (hpop || hskip) void'(mq.pop_front());
      erd = mexc ? 5'd30 : mrd;
      ed  = mexc ? (mdiv ? 32'd5 : 32'd4) : md;
      if (mv && rdy && erd != 5'd0) begin
        ne.v = 1'b1; ne.rd = erd; ne.d = ed;
        mq.push_back(ne);
      end
      emask = '0;
      foreach (mq[j]) if (mq[j].v) emask[mq[j].rd] = 1'b1;

      tick();
      e = sb.pop_front();
      check($sformatf("rnd%0d_we", c), 32'(ctrl_writeEnable), 32'(e.we));
      if (e.we) begin
        check($sformatf("rnd%0d_reg", c),  32'(ctrl_writeReg), 32'(e.r));
        check($sformatf("rnd%0d_data", c), data_writeReg,      e.d);
      end
      check($sformatf("rnd%0d_mask", c),  pending_mask, emask);
      check($sformatf("rnd%0d_ready", c), 32'(md_ready), 32'(mq.size() < 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
